// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch unit's pipeline-control, instruction-memory and IF/ID signals.
// master = fetch unit side, slave = surrounding pipeline and memory.
interface if_fetch_unit_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;
  logic        fetch_stall;

  modport master (
    input  freeze, branch_taken, branch_addr, mem_ack, mem_rdata,
    output mem_req, mem_addr, pc_out, instruction, valid, fetch_stall
  );

  modport slave (
    output freeze, branch_taken, branch_addr, mem_ack, mem_rdata,
    input  mem_req, mem_addr, pc_out, instruction, valid, fetch_stall
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding memory requests
// and presents one instruction (or a NOP bubble) per cycle to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic        r_discard;

  logic        w_ack_live;
  logic        w_hold_live;
  logic        w_valid;
  logic [31:0] w_req_next;

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + PC_STEP;
  endfunction

  // A word is only presented if it belongs to the current PC and no redirect is happening.
  assign w_ack_live  = (r_state == S_REQ) && bus.mem_ack && !r_discard && !bus.branch_taken;
  assign w_hold_live = (r_state == S_HOLD) && !bus.branch_taken;
  assign w_valid     = w_ack_live || w_hold_live;
  assign w_req_next  = pc_inc(r_req_addr);

  assign bus.mem_req     = (r_state == S_REQ);
  assign bus.mem_addr    = r_req_addr;
  assign bus.valid       = w_valid;
  assign bus.fetch_stall = !w_valid;
  assign bus.instruction = w_ack_live  ? bus.mem_rdata :
                           w_hold_live ? r_hold_instr  : NOP_INSTR;
  assign bus.pc_out      = w_ack_live  ? w_req_next    :
                           w_hold_live ? r_hold_pc     : 32'h0000_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_hold_instr <= 32'h0000_0000;
      r_hold_pc    <= 32'h0000_0000;
      r_discard    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (bus.branch_taken) begin
            r_pc       <= bus.branch_addr;
            r_req_addr <= bus.branch_addr;
          end else begin
            r_req_addr <= r_pc;
          end
        end

        S_REQ: begin
          if (bus.branch_taken) begin
            r_pc <= bus.branch_addr;
            // Without an ack the request must stay stable, so the stale word is marked for drop.
            if (bus.mem_ack) begin
              r_req_addr <= bus.branch_addr;
              r_discard  <= 1'b0;
            end else begin
              r_discard  <= 1'b1;
            end
          end else if (bus.mem_ack) begin
            if (r_discard) begin
              r_discard  <= 1'b0;
              r_req_addr <= r_pc;
            end else if (!bus.freeze) begin
              r_pc       <= w_req_next;
              r_req_addr <= w_req_next;
            end else begin
              r_hold_instr <= bus.mem_rdata;
              r_hold_pc    <= w_req_next;
              r_state      <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (bus.branch_taken) begin
            r_pc       <= bus.branch_addr;
            r_req_addr <= bus.branch_addr;
            r_state    <= S_REQ;
          end else if (!bus.freeze) begin
            r_pc       <= r_hold_pc;
            r_req_addr <= r_hold_pc;
            r_state    <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: variable-latency memory responder plus an instruction-stream
// reference model, driven by directed scenarios followed by random freeze/branch traffic.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'hE000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_unit_if bus();
  if_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  // Stream model: m_next is the address of the next instruction the pipeline should see.
  logic        m_idle, m_held, m_stale, m_txn_open;
  logic [31:0] m_next, m_txn_addr;
  // Memory responder bookkeeping.
  int          wait_cnt;
  logic        prev_req, prev_ack;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5EED_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_held = 1'b0; m_stale = 1'b0; m_txn_open = 1'b0;
    m_next = 32'h0; m_txn_addr = 32'h0;
    prev_req = 1'b0; prev_ack = 1'b0; wait_cnt = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".mem_req"},     32'(bus.mem_req), 32'h0);
    chk({tag, ".valid"},       32'(bus.valid), 32'h0);
    chk({tag, ".fetch_stall"}, 32'(bus.fetch_stall), 32'h1);
    chk({tag, ".instruction"}, bus.instruction, NOP);
    chk({tag, ".pc_out"},      bus.pc_out, 32'h0);
  endtask

  // One clock cycle; lat = total cycles a transaction starting now takes to ack.
  task automatic cycle(input logic f, input logic b, input logic [31:0] ba, input int lat);
    logic        ack, req_s, e_req, e_valid;
    logic [31:0] e_addr;
    bus.freeze = f; bus.branch_taken = b; bus.branch_addr = ba;
    req_s = bus.mem_req;
    if (req_s) begin
      if (!prev_req || prev_ack) wait_cnt = lat - 1;
      ack = (wait_cnt == 0);
    end else begin
      ack = 1'b0;
    end
    bus.mem_ack   = ack;
    bus.mem_rdata = ack ? memword(bus.mem_addr) : $urandom;
    #1;
    e_req   = !m_idle && !m_held;
    e_addr  = m_txn_open ? m_txn_addr : m_next;
    e_valid = !b && (m_held || (e_req && ack && !m_stale));
    chk("mem_req", 32'(bus.mem_req), 32'(e_req));
    if (e_req) chk("mem_addr", bus.mem_addr, e_addr);
    chk("valid", 32'(bus.valid), 32'(e_valid));
    chk("fetch_stall", 32'(bus.fetch_stall), 32'(!e_valid));
    chk("instruction", bus.instruction, e_valid ? memword(m_next) : NOP);
    chk("pc_out", bus.pc_out, e_valid ? m_next + 32'd4 : 32'h0);
    @(posedge clk); #1;
    if (e_req) m_stale = b ? !ack : (ack ? 1'b0 : m_stale);
    if (b) begin
      m_next = ba; m_held = 1'b0;
    end else if (e_valid && !f) begin
      m_next = m_next + 32'd4; m_held = 1'b0;
    end else if (e_valid && f) begin
      m_held = 1'b1;
    end
    if (e_req) begin
      m_txn_open = !ack; m_txn_addr = e_addr;
    end
    m_idle = 1'b0;
    prev_req = req_s; prev_ack = ack;
    if (req_s && !ack) wait_cnt--;
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    bus.mem_ack = 1'b0; bus.branch_taken = 1'b0; bus.freeze = 1'b0;
    #1;
    chk_reset_outputs(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic        f, b;
    logic [31:0] ba;
    rst = 1'b1;
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

    // Zero-wait streaming from reset: 0,4,8,C
    cycle(1'b0, 1'b0, 32'h0, 1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1);

    // Reset while the request for 0x10 is outstanding
    chk("pre_rst.mem_req", 32'(bus.mem_req), 32'h1);
    reset_pulse("mid_rst");
    cycle(1'b0, 1'b0, 32'h0, 1);
    chk("after_rst.mem_addr", bus.mem_addr, 32'h0);

    // 3-cycle latency on address 0, then zero-wait 4
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 3);
    cycle(1'b0, 1'b0, 32'h0, 1);

    // Freeze on the ack of 8 for two cycles, then release
    cycle(1'b1, 1'b0, 32'h0, 1);
    cycle(1'b1, 1'b0, 32'h0, 1);
    cycle(1'b0, 1'b0, 32'h0, 1);
    chk("post_hold.mem_addr", bus.mem_addr, 32'hC);
    cycle(1'b0, 1'b0, 32'h0, 1);

    // Branch during the outstanding 3-cycle request to 0x10
    chk("pre_br.mem_addr", bus.mem_addr, 32'h10);
    cycle(1'b0, 1'b1, 32'h100, 3);
    cycle(1'b0, 1'b0, 32'h0, 3);
    cycle(1'b0, 1'b0, 32'h0, 3);
    chk("redirect.mem_addr", bus.mem_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 1);

    // Branch coincident with ack, then branch while holding
    cycle(1'b0, 1'b1, 32'h200, 1);
    chk("br_ack.mem_addr", bus.mem_addr, 32'h200);
    cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b1, 1'b0, 32'h0, 1);
    cycle(1'b1, 1'b1, 32'h300, 1);
    chk("br_hold.mem_addr", bus.mem_addr, 32'h300);

    // Second branch while the first is still waiting for its stale ack
    cycle(1'b0, 1'b1, 32'h400, 3);
    cycle(1'b0, 1'b1, 32'h500, 3);
    cycle(1'b0, 1'b0, 32'h0, 3);
    chk("br_twice.mem_addr", bus.mem_addr, 32'h500);
    cycle(1'b0, 1'b0, 32'h0, 1);

    // PC wrap from 0xFFFFFFFC
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1);
    cycle(1'b0, 1'b0, 32'h0, 1);
    chk("wrap.mem_addr", bus.mem_addr, 32'h0);

    // Random freeze/branch/latency traffic
    for (int i = 0; i < 400; i++) begin
      f  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 9) == 0);
      ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(f, b, ba, int'($urandom_range(1, 3)));
    end

    reset_pulse("end_rst");
    cycle(1'b0, 1'b0, 32'h0, 1);
    cycle(1'b0, 1'b0, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
